// File: rtl/seg7_bcd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_bcd_driver
// Purpose  : Registered seven-segment driver for three packed BCD digits.
//            Captures a 12-bit BCD word over a valid/ready handshake, holds
//            off further captures for HOLD_CYCLES cycles, decodes each digit
//            to active-low segments, optionally blanks leading zeros and
//            dims the display with a free-running PWM.
// Ports    : clk         - system clock, rising edge
//            reset_n     - asynchronous active-low reset
//            bcd_in      - [11:8] hundreds, [7:4] tens, [3:0] units
//            bcd_valid   - bcd_in carries a word
//            bcd_ready   - block accepts a word this cycle
//            brightness  - PWM duty select, sampled every cycle
//            hex0..hex2  - units/tens/hundreds segments, bit0=a .. bit6=g,
//                          active-low
// Options  : define SEG7_LZB_EN to enable leading-zero blanking on hex1/hex2
// Revision : 1.0 - initial release
// ============================================================================
module seg7_bcd_driver #(
    parameter int PWM_BITS    = 4,
    parameter int HOLD_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [11:0]         bcd_in,
    input  logic                bcd_valid,
    output logic                bcd_ready,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2
);

    // Hold counter width: $clog2(HOLD_CYCLES+1), never narrower than 1 bit.
    localparam int c_CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD =
        c_CNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
    localparam bit c_HOLD_EN = (HOLD_CYCLES > 0);
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_capture;
    logic [c_CNT_W-1:0]   r_hold_cnt;
    logic [3:0]           r_hund;
    logic [3:0]           r_tens;
    logic [3:0]           r_units;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic                 w_lit;
    logic                 w_blank2;
    logic                 w_blank1;

    // Active-low decode; anything above 9 renders as a dash (segment g).
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Handshake state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready depends on state only; with the hold disabled the machine
    // never leaves IDLE and every valid cycle is a capture.
    always_comb begin
        w_state_nxt = r_state;
        bcd_ready   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bcd_ready = 1'b1;
                if (bcd_valid) begin
                    w_capture = 1'b1;
                    if (c_HOLD_EN) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Loaded with HOLD_CYCLES-1 so that ready returns exactly HOLD_CYCLES
    // edges after the capture edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
        end else if (w_capture) begin
            r_hold_cnt <= c_HOLD_LOAD;
        end else if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Digit registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (w_capture) begin
            r_hund  <= bcd_in[11:8];
            r_tens  <= bcd_in[7:4];
            r_units <= bcd_in[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Free-running PWM counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    // Inclusive compare: all-ones brightness is always lit, zero still
    // gives one lit slot per period.
    assign w_lit = (r_pwm_cnt <= brightness);

    // ------------------------------------------------------------------
    // Leading-zero blanking (a dash is nonzero, so it is never blanked)
    // ------------------------------------------------------------------
`ifdef SEG7_LZB_EN
    assign w_blank2 = (r_hund == 4'd0);
    assign w_blank1 = (r_hund == 4'd0) && (r_tens == 4'd0);
`else
    assign w_blank2 = 1'b0;
    assign w_blank1 = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered decode and PWM gating stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex0 <= c_SEG_BLANK;
            hex1 <= c_SEG_BLANK;
            hex2 <= c_SEG_BLANK;
        end else begin
            hex0 <= w_lit ? seg_decode(r_units) : c_SEG_BLANK;
            hex1 <= (w_lit && !w_blank1) ? seg_decode(r_tens) : c_SEG_BLANK;
            hex2 <= (w_lit && !w_blank2) ? seg_decode(r_hund) : c_SEG_BLANK;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_bcd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_bcd_driver
// Purpose  : Directed self-checking bench for seg7_bcd_driver with
//            HOLD_CYCLES=4 and PWM_BITS=4. Expectations follow SEG7_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_bcd_driver;

    logic        clk;
    logic        reset_n;
    logic [11:0] bcd_in;
    logic        bcd_valid;
    logic        bcd_ready;
    logic [3:0]  brightness;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;

    int total = 0;
    int bad   = 0;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] c_LZ = 7'h7F;
`else
    localparam logic [6:0] c_LZ = 7'h40;
`endif

    seg7_bcd_driver #(
        .PWM_BITS    (4),
        .HOLD_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .brightness (brightness),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference PWM: counter value before each edge decides lit/unlit
    // for the output registered on that edge.
    logic [3:0] m_pwm;
    logic       m_lit;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pwm <= 4'd0;
            m_lit <= 1'b0;
        end else begin
            m_lit <= (m_pwm <= brightness);
            m_pwm <= m_pwm + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bcd_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_wait", {11'd0, bcd_ready}, 12'd1);
    endtask

    initial begin
        int lit_cnt;
        reset_n    = 1'b0;
        bcd_in     = 12'h000;
        bcd_valid  = 1'b0;
        brightness = 4'd15;

        // Reset state
        repeat (3) step();
        chk("rst_hex0",  {5'd0, hex0}, 12'h7F);
        chk("rst_hex1",  {5'd0, hex1}, 12'h7F);
        chk("rst_hex2",  {5'd0, hex2}, 12'h7F);
        chk("rst_ready", {11'd0, bcd_ready}, 12'd1);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", {11'd0, bcd_ready}, 12'd1);
        step();
        chk("first_hex0", {5'd0, hex0}, 12'h40);
        chk("first_hex1", {5'd0, hex1}, {5'd0, c_LZ});
        chk("first_hex2", {5'd0, hex2}, {5'd0, c_LZ});

        // Capture 255 (edge N), then present 111 during HOLD
        bcd_in    = 12'h255;
        bcd_valid = 1'b1;
        step();                                         // N
        chk("hold_ready_n0", {11'd0, bcd_ready}, 12'd0);
        chk("hex0_not_yet",  {5'd0, hex0}, 12'h40);
        bcd_in = 12'h111;
        step();                                         // N+1
        chk("h255_hex2", {5'd0, hex2}, 12'h24);
        chk("h255_hex1", {5'd0, hex1}, 12'h12);
        chk("h255_hex0", {5'd0, hex0}, 12'h12);
        chk("hold_ready_n1", {11'd0, bcd_ready}, 12'd0);
        step();                                         // N+2
        chk("hold_ready_n2", {11'd0, bcd_ready}, 12'd0);
        step();                                         // N+3
        chk("hold_ready_n3", {11'd0, bcd_ready}, 12'd0);
        chk("no_cap_hex0_n3", {5'd0, hex0}, 12'h12);
        step();                                         // N+4
        chk("hold_ready_n4", {11'd0, bcd_ready}, 12'd1);
        chk("no_cap_hex2_n4", {5'd0, hex2}, 12'h24);
        step();                                         // N+5: captures 111
        chk("cap111_ready", {11'd0, bcd_ready}, 12'd0);
        chk("cap111_old_hex1", {5'd0, hex1}, 12'h12);
        bcd_valid = 1'b0;
        step();                                         // N+6
        chk("h111_hex2", {5'd0, hex2}, 12'h79);
        chk("h111_hex1", {5'd0, hex1}, 12'h79);
        chk("h111_hex0", {5'd0, hex0}, 12'h79);

        // 007: leading zeros
        wait_ready();
        bcd_in    = 12'h007;
        bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        step();
        chk("h007_hex2", {5'd0, hex2}, {5'd0, c_LZ});
        chk("h007_hex1", {5'd0, hex1}, {5'd0, c_LZ});
        chk("h007_hex0", {5'd0, hex0}, 12'h78);

        // 0A3: dash in tens blocks blanking of tens
        wait_ready();
        bcd_in    = 12'h0A3;
        bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        step();
        chk("h0a3_hex2", {5'd0, hex2}, {5'd0, c_LZ});
        chk("h0a3_hex1", {5'd0, hex1}, 12'h3F);
        chk("h0a3_hex0", {5'd0, hex0}, 12'h30);

        // PWM at brightness 3: 4 lit cycles in every 16
        brightness = 4'd3;
        lit_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("pwm_hex0", {5'd0, hex0}, m_lit ? 12'h30 : 12'h7F);
            chk("pwm_hex1", {5'd0, hex1}, m_lit ? 12'h3F : 12'h7F);
            if (hex0 != 7'h7F) lit_cnt++;
        end
        chk("pwm_lit_count", 12'(lit_cnt), 12'd8);

        // Reset asserted mid-HOLD
        brightness = 4'd15;
        wait_ready();
        bcd_in    = 12'h255;
        bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        chk("mid_hold_ready", {11'd0, bcd_ready}, 12'd0);
        step();
        chk("mid_hold_hex0", {5'd0, hex0}, 12'h12);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", {11'd0, bcd_ready}, 12'd1);
        chk("arst_hex0",  {5'd0, hex0}, 12'h7F);
        chk("arst_hex1",  {5'd0, hex1}, 12'h7F);
        chk("arst_hex2",  {5'd0, hex2}, 12'h7F);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_arst_hex0", {5'd0, hex0}, 12'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
